// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states, datapath select codes.
// Build option: MULTICYCLE_CTRL_JUMP_EN adds the JUMP state and makes opcode 2 legal.
package multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_J     = 6'd2;

  // FETCH must stay at zero so the reset state reads as an all-zero debug output.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8
`ifdef MULTICYCLE_CTRL_JUMP_EN
    ,
    JUMP     = 4'd9
`endif
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_REG     = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ);
`ifdef MULTICYCLE_CTRL_JUMP_EN
    ok = ok || (op == OP_J);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle MIPS-style datapath; FETCH/MEM_RD/MEM_WR stall on mem_ready.
// Build option: MULTICYCLE_CTRL_JUMP_EN enables the JUMP path (opcode 2); otherwise opcode 2 is illegal.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:    if (mem_ready) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_BEQ:       state_d = BRANCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
          OP_J:         state_d = JUMP;
`endif
          default:      state_d = FETCH;
        endcase
      end
      // opcode is re-read here; anything other than a load/store just abandons the instruction
      MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = MEM_RD;
        else if (opcode == OP_SW) state_d = MEM_WR;
        else                      state_d = FETCH;
      end
      MEM_RD:   if (mem_ready) state_d = MEM_WB;
      MEM_WB:   state_d = FETCH;
      MEM_WR:   if (mem_ready) state_d = FETCH;
      EXEC:     state_d = R_WB;
      R_WB:     state_d = FETCH;
      BRANCH:   state_d = FETCH;
`ifdef MULTICYCLE_CTRL_JUMP_EN
      JUMP:     state_d = FETCH;
`endif
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    illegal_op    = 1'b0;
    // outputs are held at zero for the whole reset window, not just after the first edge
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b  = SRCB_IMM_SH2;
          illegal_op = !op_legal(opcode);
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_SUB;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
        end
`ifdef MULTICYCLE_CTRL_JUMP_EN
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = PCSRC_JUMP;
        end
`endif
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: an instruction-route model predicts every output each cycle.
// Honors MULTICYCLE_CTRL_JUMP_EN the same way as the design.
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic       illegal_op;
  logic [3:0] state;

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       illegal_op;
    logic [3:0] state;
  } outs_t;

  typedef struct {
    int lat, regw, m2r, memw, irw, pcw, pwc, ill, jmp, funct, sub;
    logic [31:0] seq;
  } run_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: an instruction is a route of steps; memory steps repeat until mem_ready.
  state_t route[$];
  int     idx;
  int     n_done;

  task automatic m_restart();
    route.delete();
    route.push_back(FETCH);
    route.push_back(DECODE);
    idx = 0;
  endtask

  function automatic logic m_legal(input logic [5:0] op);
`ifdef MULTICYCLE_CTRL_JUMP_EN
    return op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd2;
`else
    return op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4;
`endif
  endfunction

  task automatic m_advance(input logic [5:0] op, input logic mr);
    state_t s = route[idx];
    if ((s == FETCH || s == MEM_RD || s == MEM_WR) && !mr) return;
    if (s == DECODE) begin
      if (op == 6'd0)  begin route.push_back(EXEC); route.push_back(R_WB); end
      if (op == 6'd35) begin route.push_back(MEM_ADDR); route.push_back(MEM_RD); route.push_back(MEM_WB); end
      if (op == 6'd43) begin route.push_back(MEM_ADDR); route.push_back(MEM_WR); end
      if (op == 6'd4)  route.push_back(BRANCH);
`ifdef MULTICYCLE_CTRL_JUMP_EN
      if (op == 6'd2)  route.push_back(JUMP);
`endif
    end
    idx++;
    if (idx >= route.size()) begin
      m_restart();
      n_done++;
    end
  endtask

  function automatic outs_t m_expect(input state_t s, input logic [5:0] op, input logic mr, input logic r);
    outs_t e = '0;
    if (r) return e;
    e.state = s;
    case (s)
      FETCH:    begin e.mem_read = 1; e.alu_src_b = 2'd1; e.ir_write = mr; e.pc_write = mr; end
      DECODE:   begin e.alu_src_b = 2'd3; e.illegal_op = !m_legal(op); end
      MEM_ADDR: begin e.alu_src_a = 1; e.alu_src_b = 2'd2; end
      MEM_RD:   begin e.mem_read = 1; e.i_or_d = 1; end
      MEM_WB:   begin e.reg_write = 1; e.mem_to_reg = 1; end
      MEM_WR:   begin e.mem_write = 1; e.i_or_d = 1; end
      EXEC:     begin e.alu_src_a = 1; e.alu_op = 2'd2; end
      R_WB:     begin e.reg_write = 1; e.reg_dst = 1; end
      BRANCH:   begin e.alu_src_a = 1; e.alu_op = 2'd1; e.pc_write_cond = 1; e.pc_source = 2'd1; end
`ifdef MULTICYCLE_CTRL_JUMP_EN
      JUMP:     begin e.pc_write = 1; e.pc_source = 2'd2; end
`endif
      default:  ;
    endcase
    return e;
  endfunction

  function automatic outs_t sample();
    outs_t g;
    g = '{pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write, reg_dst,
          mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, state};
    return g;
  endfunction

  // One clock: drive in the low phase, compare against the model, then let the edge happen.
  task automatic cycle(input logic [5:0] op, input logic mr, output outs_t got);
    outs_t exp;
    opcode    = op;
    mem_ready = mr;
    #1;
    got = sample();
    exp = m_expect(route[idx], op, mr, rst);
    check($sformatf("outputs cyc%0d step%0d", cyc, route[idx]), 32'(got), 32'(exp));
    @(posedge clk);
    if (!rst) m_advance(op, mr);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    outs_t got;
    rst = 1'b1;
    m_restart();
    #1;
    check("reset_immediate", 32'(sample()), 32'd0);
    repeat (n) cycle(6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), got);
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [5:0] op_i, input int fstall, input int mstall, output run_t r);
    outs_t  got;
    state_t s;
    logic [5:0] op;
    logic   mr;
    int     done0 = n_done;
    r = '{default: 0};
    for (int guard = 0; guard < 60; guard++) begin
      s  = route[idx];
      op = (s == DECODE || s == MEM_ADDR) ? op_i : 6'($urandom_range(0, 63));
      if (s == FETCH) begin
        if (fstall > 0) begin mr = 1'b0; fstall--; end else mr = 1'b1;
      end else if (s == MEM_RD || s == MEM_WR) begin
        if (mstall > 0) begin mr = 1'b0; mstall--; end else mr = 1'b1;
      end else begin
        mr = 1'($urandom_range(0, 1));
      end
      cycle(op, mr, got);
      r.lat++;
      r.seq   = (r.seq << 4) | 32'(got.state);
      r.regw  += int'(got.reg_write);
      r.m2r   += int'(got.mem_to_reg);
      r.memw  += int'(got.mem_write);
      r.irw   += int'(got.ir_write);
      r.pcw   += int'(got.pc_write);
      r.pwc   += int'(got.pc_write_cond);
      r.ill   += int'(got.illegal_op);
      r.jmp   += int'(got.pc_source == 2'd2);
      r.funct += int'(got.alu_op == 2'd2);
      r.sub   += int'(got.alu_op == 2'd1);
      if (n_done != done0) break;
    end
  endtask

  initial begin
    outs_t got;
    run_t  r;
    logic [5:0] op;
    opcode    = 6'd0;
    mem_ready = 1'b0;
    n_done    = 0;
    do_reset(2);

    cycle(6'd35, 1'b0, got);
    check("release_state", 32'(got.state), 32'd0);
    check("release_mem_read", 32'(got.mem_read), 32'd1);

    run_instr(6'd35, 0, 0, r);
    check("lw_latency", 32'(r.lat), 32'd5);
    check("lw_states", r.seq, 32'h0001_2340 >> 4);
    check("lw_reg_write", 32'(r.regw), 32'd1);
    check("lw_mem_to_reg", 32'(r.m2r), 32'd1);

    run_instr(6'd43, 0, 3, r);
    check("sw_latency", 32'(r.lat), 32'd7);
    check("sw_states", r.seq, 32'h0125_5555 >> 4);
    check("sw_mem_write", 32'(r.memw), 32'd4);
    check("sw_reg_write", 32'(r.regw), 32'd0);

    run_instr(6'd0, 2, 0, r);
    check("fstall_latency", 32'(r.lat), 32'd6);
    check("fstall_states", r.seq, 32'h0000_0167);
    check("fstall_ir_write", 32'(r.irw), 32'd1);
    check("fstall_pc_write", 32'(r.pcw), 32'd1);

    run_instr(6'd0, 0, 0, r);
    check("rtype_latency", 32'(r.lat), 32'd4);
    check("rtype_funct", 32'(r.funct), 32'd1);
    run_instr(6'd4, 0, 0, r);
    check("beq_latency", 32'(r.lat), 32'd3);
    check("beq_states", r.seq, 32'h0000_0018);
    check("beq_pc_write_cond", 32'(r.pwc), 32'd1);
    check("beq_sub", 32'(r.sub), 32'd1);

    run_instr(6'd63, 0, 0, r);
    check("illegal_latency", 32'(r.lat), 32'd2);
    check("illegal_pulse", 32'(r.ill), 32'd1);

    run_instr(6'd2, 0, 0, r);
`ifdef MULTICYCLE_CTRL_JUMP_EN
    check("j_latency", 32'(r.lat), 32'd3);
    check("j_pc_source", 32'(r.jmp), 32'd1);
    check("j_illegal", 32'(r.ill), 32'd0);
`else
    check("j_latency", 32'(r.lat), 32'd2);
    check("j_pc_source", 32'(r.jmp), 32'd0);
    check("j_illegal", 32'(r.ill), 32'd1);
`endif

    // abandon a stalled load mid-MEM_RD
    cycle(6'd35, 1'b1, got);
    cycle(6'd35, 1'b1, got);
    cycle(6'd35, 1'b1, got);
    cycle(6'd35, 1'b0, got);
    check("pre_reset_in_mem_rd", 32'(state), 32'd3);
    do_reset(2);
    cycle(6'd0, 1'b0, got);
    check("post_reset_state", 32'(got.state), 32'd0);
    check("post_reset_mem_read", 32'(got.mem_read), 32'd1);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    op = 6'd0;
        2:       op = 6'd35;
        3:       op = 6'd43;
        4:       op = 6'd4;
        5:       op = 6'd2;
        default: op = 6'($urandom_range(0, 63));
      endcase
      if ($urandom_range(0, 29) == 0) begin
        repeat ($urandom_range(1, 4)) cycle(op, 1'($urandom_range(0, 1)), got);
        do_reset(int'($urandom_range(0, 2)));
      end else begin
        run_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: opcode  in  6  instruction[31:26], valid from DECODE onward.
REQ-004 SHALL have ports: mem_ready  in  1  memory completes the current access this cycle.
REQ-005 SHALL have ports: pc_write, pc_write_cond, i_or_d, ir_write, mem_read, mem_write  out  1 each  datapath enables.
REQ-006 SHALL have ports: reg_dst, mem_to_reg, reg_write, alu_src_a  out  1 each  datapath selects and enables.
REQ-007 SHALL have ports: alu_src_b  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
REQ-008 SHALL have ports: alu_op  out  2  0=add, 1=sub, 2=funct-decoded.
REQ-009 SHALL have ports: pc_source  out  2  0=ALU result, 1=ALUOut, 2=jump target.
REQ-010 SHALL have ports: illegal_op  out  1  one-cycle pulse on an undecoded opcode; state  out  4  current FSM state (debug).

Function
REQ-011 SHALL be a Moore FSM: outputs decode from state only, except ir_write, pc_write and the memory-state exits, which are additionally gated by mem_ready.
REQ-012 SHALL use states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB, BRANCH, JUMP.
REQ-013 FETCH SHALL drive mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0; ir_write=pc_write=mem_ready; hold until mem_ready=1, then go to DECODE.
REQ-014 DECODE SHALL drive alu_src_a=0, alu_src_b=3, alu_op=0; next state: opcode 0->EXEC, 35 or 43->MEM_ADDR, 4->BRANCH, 2->JUMP (JUMP_EN only), otherwise FETCH with illegal_op=1 for that cycle.
REQ-015 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=2, alu_op=0; go to MEM_RD for opcode 35, MEM_WR for 43.
REQ-016 MEM_RD SHALL drive mem_read=1, i_or_d=1 and hold until mem_ready; then go to MEM_WB.
REQ-017 MEM_WB SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-018 MEM_WR SHALL drive mem_write=1, i_or_d=1 and hold until mem_ready; then go to FETCH.
REQ-019 EXEC SHALL drive alu_src_a=1, alu_src_b=0, alu_op=2, then go to R_WB; R_WB SHALL drive reg_write=1, reg_dst=1, mem_to_reg=0, then go to FETCH.
REQ-020 BRANCH SHALL drive alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1, then go to FETCH.
REQ-021 JUMP SHALL drive pc_write=1, pc_source=2, then go to FETCH.
REQ-022 Every output not listed for a state SHALL be 0; mem_read and mem_write SHALL never be high together.
REQ-023 Latencies with mem_ready always 1: R-type 4 cycles, LW 5, SW 4, BEQ 3, J 3.
REQ-024 mem_ready outside FETCH/MEM_RD/MEM_WR SHALL be ignored; opcode SHALL be sampled only in DECODE and MEM_ADDR.

Reset
REQ-025 rst=1 SHALL force state=FETCH immediately, asynchronously, including mid-access; an in-flight memory access is abandoned.
REQ-026 While rst=1, all outputs SHALL be 0, illegal_op included; on the first edge after release the FSM SHALL be in FETCH with mem_read=1.

Configuration
REQ-027 Macro MULTICYCLE_CTRL_JUMP_EN SHALL control jump support: defined: opcode 2 -> JUMP; undefined: JUMP state is absent, opcode 2 is illegal, and pc_source never equals 2.

Structure
REQ-028 Shared package SHALL hold the opcode constants OP_RTYPE=0, OP_LW=35, OP_SW=43, OP_BEQ=4, OP_J=2, the state encoding (4-bit enum), and the alu_op/alu_src_b/pc_source encodings.
REQ-029 SHALL be one module with no sub-modules; next-state and output decode are separate combinational processes.

Verification
REQ-030 Reset mid-MEM_RD (mem_ready=0) -> state=FETCH the same cycle, all outputs 0 until release, then mem_read=1.
REQ-031 opcode=35, mem_ready=1 -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, FETCH; reg_write=1 and mem_to_reg=1 only in MEM_WB.
REQ-032 opcode=43 with mem_ready low for 3 cycles in MEM_WR -> mem_write held high for 4 cycles, then FETCH; reg_write never 1.
REQ-033 FETCH with mem_ready low for 2 cycles -> ir_write=pc_write=0 for 2 cycles, 1 only in the cycle where mem_ready=1.
REQ-034 opcode=0 then opcode=4 -> 4-cycle R-type with alu_op=2 in EXEC, then 3-cycle branch with pc_write_cond=1 and alu_op=1.
REQ-035 opcode=63 -> illegal_op pulses 1 cycle in DECODE, then FETCH; opcode=2 -> JUMP with the macro defined, illegal_op without it.
